// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the CPU data-memory responder: segment base, FSM states,
// and the word-offset range check.
package dmem_responder_pkg;

  localparam logic [31:0] DMEM_BASE = 32'h1001_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // True when a byte offset from the segment base is word aligned and within
  // the first 'depth' words.
  function automatic logic word_in_range(input logic [31:0] off, input int unsigned depth);
    return (off[1:0] == 2'b00) && ({2'b00, off[31:2]} < depth);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-memory port: request strobe, direction, address and data in both directions.
interface dmem_responder_if;
  logic        cs;
  logic        dm_w;
  logic        dm_r;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output cs, dm_w, dm_r, addr, data_in,
    input  data_out, ready, err, busy
  );

  modport slave (
    input  cs, dm_w, dm_r, addr, data_in,
    output data_out, ready, err, busy
  );
endinterface

// File: rtl/dmem_responder_array.sv
// Single-port word RAM with synchronous write and registered synchronous read.
// The read register only updates on a read, so it doubles as the held read result.
module dmem_array #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // Storage has no reset: contents survive a reset of the responder.
  always_ff @(posedge clk) begin
    if (we) mem[index] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[index];
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder for the CPU data port: decodes the byte address against the data
// segment, inserts fixed wait states, and reports completion with ready/err pulses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IW      = $clog2(DEPTH);
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        w_q, r_q;
  logic        err_q;

  logic          accept;
  logic          access;
  logic          bad;
  logic [31:0]   off;
  logic [IW-1:0] index;
  logic          we, re;

  assign accept = (state_q != S_BUSY) && bus.cs && (bus.dm_w || bus.dm_r);
  assign access = (state_q == S_BUSY) && (cnt_q == '0);

  assign off   = addr_q - BASE_ADDR;
  assign index = off[IW+1:2];
  assign bad   = (addr_q < BASE_ADDR) || !word_in_range(off, DEPTH) || (w_q && r_q);

  assign we = access && !bad && w_q;
  assign re = access && !bad && r_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      w_q     <= 1'b0;
      r_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.data_in;
        w_q     <= bus.dm_w;
        r_q     <= bus.dm_r;
      end
      if (access) err_q <= bad;
    end
  end

  // RESP accepts like IDLE so back-to-back requests lose no cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = WS_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) cnt_d   = cnt_q - 4'd1;
        else             state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready = (state_q == S_RESP);
  assign bus.err   = (state_q == S_RESP) && err_q;
  assign bus.busy  = (state_q == S_BUSY);

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk_in),
    .rst_n (reset),
    .we    (we),
    .re    (re),
    .index (index),
    .wdata (wdata_q),
    .rdata (bus.data_out)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (2 and 0 wait states) share
// the stimulus; a negedge monitor checks err, data_out and ready timing.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic cs = 1'b0, dm_w = 1'b0, dm_r = 1'b0;
  logic [31:0] addr = '0, data_in = '0;
  int unsigned cyc = 0;
  int unsigned ws = 2;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  assign bus0.cs      = cs && !sel;
  assign bus0.dm_w    = dm_w;
  assign bus0.dm_r    = dm_r;
  assign bus0.addr    = addr;
  assign bus0.data_in = data_in;
  assign bus1.cs      = cs && sel;
  assign bus1.dm_w    = dm_w;
  assign bus1.dm_r    = dm_r;
  assign bus1.addr    = addr;
  assign bus1.data_in = data_in;

  logic        ready_m, err_m, busy_m;
  logic [31:0] dout_m;
  assign ready_m = sel ? bus1.ready    : bus0.ready;
  assign err_m   = sel ? bus1.err      : bus0.err;
  assign busy_m  = sel ? bus1.busy     : bus0.busy;
  assign dout_m  = sel ? bus1.data_out : bus0.data_out;

  dmem_responder #(.BASE_ADDR(32'h1001_0000), .DEPTH(1024), .WAIT_STATES(2)) dut_ws2 (
    .clk_in (clk),
    .reset  (rst_n),
    .bus    (bus0)
  );

  dmem_responder #(.BASE_ADDR(32'h1001_0000), .DEPTH(1024), .WAIT_STATES(0)) dut_ws0 (
    .clk_in (clk),
    .reset  (rst_n),
    .bus    (bus1)
  );

  typedef struct {
    logic        err;
    logic [31:0] dout;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t q[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ready_m) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ready: got ready=1 at cycle %0d want no response", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, "_err"},   32'(err_m), 32'(e.err));
          chk({e.name, "_dout"},  dout_m,     e.dout);
          chk({e.name, "_cycle"}, cyc,        e.due);
        end
      end else if (err_m) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_err: got err=1 without ready at cycle %0d want err=0", cyc);
      end
    end
  end

  // Called on a negedge; holds the request until the DUT can take it.
  task automatic issue(input string nm, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_dout);
    int unsigned tries = 0;
    cs = 1'b1; dm_w = w; dm_r = r; addr = a; data_in = d;
    while (busy_m && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept: got busy for %0d cycles want accept", nm, tries);
    end else begin
      @(posedge clk);
      #1;
      q.push_back('{e_err, e_dout, cyc + ws + 1, nm});
    end
    @(negedge clk);
    cs = 1'b0; dm_w = 1'b0; dm_r = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d responses outstanding want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready_ws2", 32'(bus0.ready), 32'd0);
    chk("rst_err_ws2",   32'(bus0.err),   32'd0);
    chk("rst_busy_ws2",  32'(bus0.busy),  32'd0);
    chk("rst_dout_ws2",  bus0.data_out,   32'd0);
    chk("rst_ready_ws0", 32'(bus1.ready), 32'd0);
    chk("rst_busy_ws0",  32'(bus1.busy),  32'd0);
    chk("rst_dout_ws0",  bus1.data_out,   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two wait states
    issue("wr_beef", 1, 0, 32'h1001_0004, 32'hDEAD_BEEF, 0, 32'h0);
    drain();
    issue("rd_beef", 0, 1, 32'h1001_0004, 32'h0, 0, 32'hDEAD_BEEF);
    drain();
    issue("rd_below",  0, 1, 32'h1000_FFFC, 32'h0, 1, 32'hDEAD_BEEF);
    issue("rd_above",  0, 1, 32'h1001_1000, 32'h0, 1, 32'hDEAD_BEEF);
    issue("rd_unalgn", 0, 1, 32'h1001_0002, 32'h0, 1, 32'hDEAD_BEEF);
    drain();
    issue("wr_1234",  1, 0, 32'h1001_0008, 32'h1234_5678, 0, 32'hDEAD_BEEF);
    issue("wr_rd_both", 1, 1, 32'h1001_0008, 32'hFFFF_FFFF, 1, 32'hDEAD_BEEF);
    issue("rd_1234",  0, 1, 32'h1001_0008, 32'h0, 0, 32'h1234_5678);
    drain();
    issue("b2b_wr_top", 1, 0, 32'h1001_0FFC, 32'hCAFE_F00D, 0, 32'h1234_5678);
    issue("b2b_rd_top", 0, 1, 32'h1001_0FFC, 32'h0, 0, 32'hCAFE_F00D);
    issue("b2b_rd_4",   0, 1, 32'h1001_0004, 32'h0, 0, 32'hDEAD_BEEF);
    drain();
    issue("wr_1111", 1, 0, 32'h1001_0010, 32'h1111_2222, 0, 32'hDEAD_BEEF);
    drain();

    // Abort a write in BUSY with reset
    cs = 1'b1; dm_w = 1'b1; dm_r = 1'b0; addr = 32'h1001_0010; data_in = 32'hA5A5_A5A5;
    @(posedge clk);
    @(negedge clk);
    cs = 1'b0; dm_w = 1'b0;
    chk("abort_busy_before", 32'(bus0.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy_in_rst", 32'(bus0.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue("rd_after_abort", 0, 1, 32'h1001_0010, 32'h0, 0, 32'h1111_2222);
    drain();

    // Zero wait states
    sel = 1'b1;
    ws  = 0;
    @(negedge clk);
    issue("ws0_wr_beef", 1, 0, 32'h1001_0004, 32'hDEAD_BEEF, 0, 32'h0);
    drain();
    issue("ws0_rd_beef", 0, 1, 32'h1001_0004, 32'h0, 0, 32'hDEAD_BEEF);
    drain();
    issue("ws0_b2b_wr", 1, 0, 32'h1001_000C, 32'h0BAD_F00D, 0, 32'hDEAD_BEEF);
    issue("ws0_b2b_rd", 0, 1, 32'h1001_000C, 32'h0, 0, 32'h0BAD_F00D);
    issue("ws0_b2b_rd4", 0, 1, 32'h1001_0004, 32'h0, 0, 32'hDEAD_BEEF);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
